// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store unit.
//   lsu_state_e   - FSM states
//   F3_*          - funct3 access codes (loads use all five, stores the first three)
//   SZ_*          - access size, funct3[1:0]
//   NUM_LANES/VEC_W - byte-lane geometry of a 32-bit word
//   lsu_req_t     - request fields latched at accept
//   f3_legal()    - legality check of funct3 for a load or a store
package lsu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPTURE,
    S_MERGE,
    S_WRITE,
    S_DONE
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;

  typedef struct packed {
    logic [2:0] funct3;
    logic       rd;   // load (otherwise store when a memory path is taken)
    logic       err;  // completes with respError
  } lsu_req_t;

  function automatic logic f3_legal(input logic [2:0] f3, input logic is_load);
    if (is_load) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                        (f3 == F3_BU) || (f3 == F3_HU);
    else         return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request/response and DataMemory signals of the LSU.
//   slave  - LSU side: takes the request and memReadData, drives the rest
//   master - environment side (controller + DataMemory)
interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  reqValid;
  logic                  reqReady;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] writeData;
  logic                  memWrite;
  logic                  memRead;
  logic [2:0]            funct3;
  logic                  respValid;
  logic                  respError;
  logic [DATA_WIDTH-1:0] loadData;
  logic [31:0]           memPosition;
  logic [DATA_WIDTH-1:0] memWriteData;
  logic                  memWriteEn;
  logic                  memReadEn;
  logic [DATA_WIDTH-1:0] memReadData;

  modport slave (
    input  reqValid, address, writeData, memWrite, memRead, funct3, memReadData,
    output reqReady, respValid, respError, loadData, memPosition, memWriteData,
           memWriteEn, memReadEn
  );

  modport master (
    output reqValid, address, writeData, memWrite, memRead, funct3, memReadData,
    input  reqReady, respValid, respError, loadData, memPosition, memWriteData,
           memWriteEn, memReadEn
  );
endinterface

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational lane logic of the LSU.
//   rdata_i   - word read from DataMemory
//   addr_lo_i - byte offset within the word
//   funct3_i  - access size/sign
//   wdata_i   - store data (low bits used for sub-word stores)
//   load_o    - selected lane, sign- or zero-extended
//   merge_o   - rdata_i with the addressed lane(s) replaced by store data
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [NUM_LANES-1:0][VEC_W-1:0] rdata_i,
  input  logic [1:0]                      addr_lo_i,
  input  logic [2:0]                      funct3_i,
  input  logic [31:0]                     wdata_i,
  output logic [31:0]                     load_o,
  output logic [NUM_LANES-1:0][VEC_W-1:0] merge_o
);
  logic [NUM_LANES-1:0]            be;
  logic [NUM_LANES-1:0][VEC_W-1:0] wrep;
  logic [7:0]                      bsel;
  logic [15:0]                     hsel;
  logic                            sext;

  // Store data is replicated across lanes so each lane only needs its enable.
  always_comb begin
    be   = '1;
    wrep = wdata_i;
    unique case (funct3_i[1:0])
      SZ_B: begin
        be   = 4'b0001 << addr_lo_i;
        wrep = {NUM_LANES{wdata_i[7:0]}};
      end
      SZ_H: begin
        be   = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wrep = {(NUM_LANES/2){wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign merge_o[g] = be[g] ? wrep[g] : rdata_i[g];
  end

  // Halfword lane comes from addr[1] only; addr[0] is ignored here.
  always_comb begin
    bsel   = rdata_i[addr_lo_i];
    hsel   = addr_lo_i[1] ? {rdata_i[3], rdata_i[2]} : {rdata_i[1], rdata_i[0]};
    sext   = ~funct3_i[2];
    load_o = rdata_i;
    unique case (funct3_i[1:0])
      SZ_B:    load_o = {{24{sext & bsel[7]}}, bsel};
      SZ_H:    load_o = {{16{sext & hsel[15]}}, hsel};
      default: ;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage between ALU/Controller and DataMemory.
// One request at a time; sub-word stores are read-modify-write.
//   clock, reset - rising-edge clock, synchronous active-high reset
//   bus          - load_store_unit_if.slave (request, response, DataMemory)
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned halfword/word
// accesses complete as errors instead of ignoring the low address bits.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 32
) (
  input logic clock,
  input logic reset,
  load_store_unit_if.slave bus
);
  localparam int IDX_W = $clog2(MEM_DEPTH);

  lsu_state_e           state_q, state_d;
  lsu_req_t             req_q;
  logic [IDX_W+1:0]     addr_q;
  logic [31:0]          wword_q;
  logic [31:0]          load_q;
  logic                 accept;
  logic                 bad;
  logic [31:0]          load_ext;
  logic [31:0]          merged;
  logic                 addr_unused;

  assign addr_unused = ^bus.address[ADDR_WIDTH-1:IDX_W+2];
  assign accept      = bus.reqValid && (state_q == S_IDLE);

  // Request decode at accept.
  always_comb begin
    bad = 1'b0;
    if (bus.memRead && bus.memWrite) bad = 1'b1;
    else if (bus.memRead)            bad = !f3_legal(bus.funct3, 1'b1);
    else if (bus.memWrite)           bad = !f3_legal(bus.funct3, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
    if ((bus.memRead || bus.memWrite) &&
        (((bus.funct3[1:0] == SZ_H) && bus.address[0]) ||
         ((bus.funct3[1:0] == SZ_W) && (bus.address[1:0] != 2'b00))))
      bad = 1'b1;
`endif
  end

  lsu_lane_align u_align (
    .rdata_i   (bus.memReadData),
    .addr_lo_i (addr_q[1:0]),
    .funct3_i  (req_q.funct3),
    .wdata_i   (wword_q),
    .load_o    (load_ext),
    .merge_o   (merged)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) begin
        if (bad || !(bus.memRead || bus.memWrite))              state_d = S_DONE;
        else if (bus.memWrite && (bus.funct3[1:0] == SZ_W))     state_d = S_WRITE;
        else                                                    state_d = S_READ;
      end
      S_READ:    state_d = req_q.rd ? S_CAPTURE : S_MERGE;
      S_CAPTURE: state_d = S_DONE;
      S_MERGE:   state_d = S_WRITE;
      S_WRITE:   state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Datapath latches. wword_q holds the raw store data until MERGE
  // overwrites it with the merged word, so one register serves both.
  always_ff @(posedge clock) begin
    if (reset) begin
      req_q   <= '0;
      addr_q  <= '0;
      wword_q <= '0;
      load_q  <= '0;
    end else begin
      if (accept) begin
        req_q   <= '{funct3: bus.funct3, rd: bus.memRead, err: bad};
        addr_q  <= bus.address[IDX_W+1:0];
        wword_q <= bus.writeData;
      end
      if (state_q == S_MERGE)   wword_q <= merged;
      if (state_q == S_CAPTURE) load_q  <= load_ext;
    end
  end

  // Outputs, decoded from the state register only.
  always_comb begin
    bus.reqReady     = (state_q == S_IDLE);
    bus.memReadEn    = (state_q == S_READ);
    bus.memWriteEn   = (state_q == S_WRITE);
    bus.respValid    = (state_q == S_DONE);
    bus.respError    = (state_q == S_DONE) && req_q.err;
    bus.memWriteData = (state_q == S_WRITE) ? wword_q : '0;
    bus.memPosition  = 32'(addr_q[IDX_W+1:2]);
    bus.loadData     = load_q;
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed test of load_store_unit against a DataMemory
// model whose reset image is word i = i.
module tb_load_store_unit;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  load_store_unit_if bus ();
  load_store_unit dut (.clock(clock), .reset(reset), .bus(bus));

  logic [31:0] mem [0:31];
  logic        mem_init;

  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'(i);
      bus.memReadData <= '0;
    end else begin
      if (bus.memWriteEn) mem[bus.memPosition[4:0]] <= bus.memWriteData;
      if (bus.memReadEn)  bus.memReadData <= mem[bus.memPosition[4:0]];
    end
  end

  int compared   = 0;
  int mismatched = 0;

  logic        t_got, t_err, t_rd, t_wr, t_both;
  logic [31:0] t_lat, t_pos;
  logic [31:0] ld_exp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    int guard = 0;
    while (!bus.reqReady && guard < 20) begin @(negedge clock); guard++; end
    bus.memRead = rd; bus.memWrite = wr; bus.funct3 = f3;
    bus.address = a;  bus.writeData = wd; bus.reqValid = 1'b1;
    @(posedge clock);
    #1 bus.reqValid = 1'b0; bus.memRead = 1'b0; bus.memWrite = 1'b0;
  endtask

  // Issue a request and follow it to respValid (cycle 0 = accept edge).
  task automatic run(input string tag, input logic rd, input logic wr,
                     input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    issue(rd, wr, f3, a, wd);
    t_got = 0; t_err = 0; t_rd = 0; t_wr = 0; t_both = 0; t_lat = 0; t_pos = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clock);
      if (bus.memReadEn)  begin t_rd = 1; t_pos = bus.memPosition; end
      if (bus.memWriteEn) begin t_wr = 1; t_pos = bus.memPosition; end
      if (bus.memReadEn && bus.memWriteEn) t_both = 1;
      if (bus.respValid) begin t_got = 1; t_lat = 32'(c); t_err = bus.respError; break; end
    end
    chk({tag, "_resp"}, {31'd0, t_got}, 32'd1);
    chk({tag, "_both"}, {31'd0, t_both}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.reqValid = 0; bus.memRead = 0; bus.memWrite = 0; bus.funct3 = 0;
    bus.address = 0;  bus.writeData = 0;
    reset = 1'b1; mem_init = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_ready",  {31'd0, bus.reqReady},   32'd1);
    chk("rst_rvalid", {31'd0, bus.respValid},  32'd0);
    chk("rst_re",     {31'd0, bus.memReadEn},  32'd0);
    chk("rst_we",     {31'd0, bus.memWriteEn}, 32'd0);
    chk("rst_load",   bus.loadData,            32'd0);
    chk("rst_pos",    bus.memPosition,         32'd0);
    chk("rst_wdata",  bus.memWriteData,        32'd0);
    reset = 1'b0; mem_init = 1'b0;

    run("lw14", 1, 0, 3'b010, 32'h14, 0);
    chk("lw14_lat", t_lat, 3); chk("lw14_pos", t_pos, 5);
    chk("lw14_err", {31'd0, t_err}, 0); chk("lw14_data", bus.loadData, 32'h5);
    chk("lw14_nowr", {31'd0, t_wr}, 0);

    run("sb0d", 0, 1, 3'b000, 32'h0D, 32'h000000AB);
    chk("sb0d_lat", t_lat, 4); chk("sb0d_err", {31'd0, t_err}, 0);
    chk("sb0d_mem", mem[3], 32'h0000AB03); chk("sb0d_pos", t_pos, 3);
    run("lbu0d", 1, 0, 3'b100, 32'h0D, 0);
    chk("lbu0d_data", bus.loadData, 32'h000000AB);
    run("lb0d", 1, 0, 3'b000, 32'h0D, 0);
    chk("lb0d_data", bus.loadData, 32'hFFFFFFAB);

    run("sh1a", 0, 1, 3'b001, 32'h1A, 32'h00008001);
    chk("sh1a_lat", t_lat, 4); chk("sh1a_mem", mem[6], 32'h80010006);
    run("lh1a", 1, 0, 3'b001, 32'h1A, 0);
    chk("lh1a_data", bus.loadData, 32'hFFFF8001);
    run("lhu1a", 1, 0, 3'b101, 32'h1A, 0);
    chk("lhu1a_data", bus.loadData, 32'h00008001);

    run("sw20", 0, 1, 3'b010, 32'h20, 32'hDEADBEEF);
    chk("sw20_lat", t_lat, 2); chk("sw20_mem", mem[8], 32'hDEADBEEF);
    chk("sw20_nord", {31'd0, t_rd}, 0);
    run("lw20", 1, 0, 3'b010, 32'h20, 0);
    chk("lw20_data", bus.loadData, 32'hDEADBEEF);
    ld_exp = 32'hDEADBEEF;

    run("lw06", 1, 0, 3'b010, 32'h06, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("lw06_lat", t_lat, 1); chk("lw06_err", {31'd0, t_err}, 1);
    chk("lw06_strb", {30'd0, t_rd, t_wr}, 0); chk("lw06_data", bus.loadData, ld_exp);
`else
    chk("lw06_lat", t_lat, 3); chk("lw06_err", {31'd0, t_err}, 0);
    chk("lw06_data", bus.loadData, 32'h1);
    ld_exp = 32'h1;
    run("lh1b", 1, 0, 3'b001, 32'h1B, 0);
    chk("lh1b_data", bus.loadData, 32'hFFFF8001);
    ld_exp = 32'hFFFF8001;
`endif

    run("rdwr", 1, 1, 3'b010, 32'h14, 32'h12345678);
    chk("rdwr_lat", t_lat, 1); chk("rdwr_err", {31'd0, t_err}, 1);
    chk("rdwr_strb", {30'd0, t_rd, t_wr}, 0); chk("rdwr_data", bus.loadData, ld_exp);
    chk("rdwr_mem", mem[5], 32'h5);

    run("ld011", 1, 0, 3'b011, 32'h14, 0);
    chk("ld011_lat", t_lat, 1); chk("ld011_err", {31'd0, t_err}, 1);
    chk("ld011_strb", {30'd0, t_rd, t_wr}, 0); chk("ld011_data", bus.loadData, ld_exp);

    run("st100", 0, 1, 3'b100, 32'h14, 32'hFF);
    chk("st100_err", {31'd0, t_err}, 1); chk("st100_strb", {30'd0, t_rd, t_wr}, 0);

    run("noop", 0, 0, 3'b010, 32'h14, 0);
    chk("noop_lat", t_lat, 1); chk("noop_err", {31'd0, t_err}, 0);
    chk("noop_strb", {30'd0, t_rd, t_wr}, 0); chk("noop_data", bus.loadData, ld_exp);

    // Reset while an SB sits in MERGE.
    issue(0, 1, 3'b000, 32'h11, 32'h55);
    @(negedge clock);
    chk("rm_read", {31'd0, bus.memReadEn}, 1);
    @(negedge clock);
    chk("rm_merge_strb", {30'd0, bus.memReadEn, bus.memWriteEn}, 0);
    reset = 1'b1;
    @(negedge clock);
    chk("rm_ready", {31'd0, bus.reqReady},   1);
    chk("rm_we",    {31'd0, bus.memWriteEn}, 0);
    chk("rm_rv",    {31'd0, bus.respValid},  0);
    chk("rm_load",  bus.loadData,            0);
    chk("rm_pos",   bus.memPosition,         0);
    chk("rm_wdata", bus.memWriteData,        0);
    reset = 1'b0;
    t_wr = 0;
    repeat (5) begin @(negedge clock); if (bus.memWriteEn) t_wr = 1; end
    chk("rm_nowr", {31'd0, t_wr}, 0);
    chk("rm_mem",  mem[4], 32'h4);

    run("lw10", 1, 0, 3'b010, 32'h10, 0);
    chk("lw10_lat", t_lat, 3); chk("lw10_data", bus.loadData, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
